uart_tx_cfg: RTL and testbench

//   Parametrised UART transmitter; next generation of uart_tx. Serialises one word per

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_gen.sv | 27 ++
 rtl/uart_tx_cfg.sv | 141 ++++++++++++++
 tb/tb_uart_tx_cfg.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes and frame FSM states, common to the
// transmitter and the matching receiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: runs 0..CLK_GOAL-1 while enabled, flags the last clock
// of each bit period with bit_tick.
module uart_baud_gen #(
  parameter  int CLK_GOAL = 434,
  localparam int CW       = (CLK_GOAL > 1) ? $clog2(CLK_GOAL) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          bit_tick
);

  assign bit_tick = en && (cnt == CW'(CLK_GOAL - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with valid/ready input: start, DATA_BITS data
// (LSB first), optional parity, 1 or 2 stop bits on a registered uart_txd.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_F     = 50_000_000,
  parameter int UART_BPS  = 115200,
  parameter int CLK_GOAL  = CLK_F / UART_BPS,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] uart_data_in,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 uart_txd,
  output logic                 tx_done
);

  localparam int CW = (CLK_GOAL > 1) ? $clog2(CLK_GOAL) : 1;
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  if (CLK_GOAL < 2) begin : g_bad_goal
    $error("uart_tx_cfg: CLK_GOAL must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  uart_state_e          state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [CW-1:0]        cnt;
  logic                 bit_tick;
  logic                 handshake;
  logic                 near_end;

  assign handshake = (state == S_IDLE) && tx_valid && tx_ready;
  // One clock before the final tick of the last stop bit, so the registered
  // tx_done lands in that bit's final clock.
  assign near_end  = (state == S_STOP) && (stop_idx == LAST_STOP) &&
                     (cnt == CW'(CLK_GOAL - 2));

  uart_baud_gen #(.CLK_GOAL(CLK_GOAL)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (handshake),
    .en       (state != S_IDLE),
    .cnt      (cnt),
    .bit_tick (bit_tick)
  );

  // NOTE: all state and outputs are registers updated with non-blocking
  // assignments; the shift register is reset too since it is only a few flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      uart_txd <= 1'b1;
      tx_ready <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      tx_done <= near_end;
      case (state)
        S_IDLE: begin
          uart_txd <= 1'b1;
          tx_ready <= 1'b1;
          if (handshake) begin
            shreg    <= uart_data_in;
            par_bit  <= (PARITY == PAR_ODD) ? ~^uart_data_in : ^uart_data_in;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
            uart_txd <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (bit_tick) begin
            uart_txd <= shreg[0];
            shreg    <= shreg >> 1;
            bit_idx  <= '0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_BIT) begin
              stop_idx <= 1'b0;
              if (PARITY != PAR_NONE) begin
                uart_txd <= par_bit;
                state    <= S_PARITY;
              end else begin
                uart_txd <= 1'b1;
                state    <= S_STOP;
              end
            end else begin
              uart_txd <= shreg[0];
              shreg    <= shreg >> 1;
              bit_idx  <= bit_idx + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (bit_tick) begin
            uart_txd <= 1'b1;
            state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            if (stop_idx == LAST_STOP) begin
              tx_busy  <= 1'b0;
              tx_ready <= 1'b1;
              state    <= S_IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations, table vectors, hand sequences for
// back-to-back, busy-time input changes and mid-frame reset, plus random words.
module tb_uart_tx_cfg;

  localparam int NK = 4;

  logic       clk = 1'b0;
  logic [3:0] rst_n_v = '0;
  logic [3:0] valid_v = '0;
  logic [8:0] din [NK];
  logic [3:0] txd, ready, busy, done;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  // k0: defaults (434 clk/bit, 8N1); k1: 4 clk/bit 8E1; k2: 3 clk/bit 7N2; k3: 2 clk/bit 9O2
  uart_tx_cfg dut0 (
    .clk(clk), .rst_n(rst_n_v[0]), .tx_valid(valid_v[0]), .uart_data_in(din[0][7:0]),
    .tx_ready(ready[0]), .tx_busy(busy[0]), .uart_txd(txd[0]), .tx_done(done[0]));
  uart_tx_cfg #(.CLK_F(400), .UART_BPS(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n_v[1]), .tx_valid(valid_v[1]), .uart_data_in(din[1][7:0]),
    .tx_ready(ready[1]), .tx_busy(busy[1]), .uart_txd(txd[1]), .tx_done(done[1]));
  uart_tx_cfg #(.CLK_F(300), .UART_BPS(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n_v[2]), .tx_valid(valid_v[2]), .uart_data_in(din[2][6:0]),
    .tx_ready(ready[2]), .tx_busy(busy[2]), .uart_txd(txd[2]), .tx_done(done[2]));
  uart_tx_cfg #(.CLK_F(200), .UART_BPS(100), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) dut3 (
    .clk(clk), .rst_n(rst_n_v[3]), .tx_valid(valid_v[3]), .uart_data_in(din[3]),
    .tx_ready(ready[3]), .tx_busy(busy[3]), .uart_txd(txd[3]), .tx_done(done[3]));

  function automatic int goal_of(int k);
    case (k) 0: return 434; 1: return 4; 2: return 3; default: return 2; endcase
  endfunction
  function automatic int dbits_of(int k);
    case (k) 2: return 7; 3: return 9; default: return 8; endcase
  endfunction
  function automatic int par_of(int k);
    case (k) 1: return 2; 3: return 1; default: return 0; endcase
  endfunction
  function automatic int stop_of(int k);
    return (k >= 2) ? 2 : 1;
  endfunction
  function automatic int nbits_of(int k);
    return 1 + dbits_of(k) + ((par_of(k) != 0) ? 1 : 0) + stop_of(k);
  endfunction

  // Reference: the line level during bit slot p of a frame carrying word w.
  function automatic logic exp_bit(int k, logic [8:0] w, int p);
    int db = dbits_of(k);
    int ones = 0;
    if (p == 0) return 1'b0;
    p = p - 1;
    if (p < db) return w[p];
    p = p - db;
    if (par_of(k) != 0) begin
      if (p == 0) begin
        for (int b = 0; b < db; b++) ones += int'(w[b]);
        return (par_of(k) == 2) ? logic'(ones % 2) : logic'((ones + 1) % 2);
      end
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hands one word to instance k and follows the whole frame clock by clock.
  // ev >= 0: at that clock of the frame, zero the data and pulse tx_valid.
  task automatic send_frame(input int k, input logic [8:0] w, input bit keep,
                            input int ev, input string name,
                            output int done_at, output logic [15:0] cap, output longint hs_t);
    int g, n, bad, t;
    g = goal_of(k); n = nbits_of(k) * g; bad = 0; done_at = -1; cap = '0; t = 0;
    while (!ready[k] && t < 10000) begin @(negedge clk); t++; end
    check({name, " ready"}, 32'(ready[k]), 32'd1);
    din[k] = w;
    valid_v[k] = 1'b1;
    @(posedge clk);
    hs_t = longint'($time);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0 && !keep) valid_v[k] = 1'b0;
      if (i == ev) begin din[k] = '0; valid_v[k] = 1'b1; end
      if (ev >= 0 && i == ev + 1) valid_v[k] = keep;
      if (txd[k] !== exp_bit(k, w, i / g) || busy[k] !== 1'b1 || ready[k] !== 1'b0) bad++;
      if (done[k] === 1'b1) begin
        if (done_at < 0) done_at = i + 1;
        else bad++;
      end
      if (i % g == g / 2) cap[i / g] = txd[k];
    end
    @(negedge clk);
    check({name, " frame"}, 32'(bad), 32'd0);
    check({name, " done_at"}, 32'(done_at), 32'(n));
    check({name, " idle rdy/busy/txd/done"}, {28'd0, ready[k], busy[k], txd[k], done[k]}, 32'b1010);
  endtask

  typedef struct {
    int          k;
    logic [8:0]  word;
    logic [15:0] exp_cap;
    int          exp_len;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int          da, nd;
    logic [15:0] cap;
    longint      t1, t2;
    logic [8:0]  w;

    vecs[0] = '{k: 0, word: 9'h0AC, exp_cap: 16'h0358, exp_len: 4340};
    vecs[1] = '{k: 1, word: 9'h06E, exp_cap: 16'h06DC, exp_len: 44};
    vecs[2] = '{k: 1, word: 9'h000, exp_cap: 16'h0400, exp_len: 44};
    vecs[3] = '{k: 2, word: 9'h042, exp_cap: 16'h0384, exp_len: 30};
    vecs[4] = '{k: 3, word: 9'h06E, exp_cap: 16'h18DC, exp_len: 26};
    vecs[5] = '{k: 3, word: 9'h1FF, exp_cap: 16'h1BFE, exp_len: 26};
    vecs[6] = '{k: 3, word: 9'h000, exp_cap: 16'h1C00, exp_len: 26};

    for (int k = 0; k < NK; k++) din[k] = '0;
    repeat (3) @(negedge clk);
    check("reset ready", 32'(ready), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset txd", 32'(txd), 32'hF);
    check("reset done", 32'(done), 32'h0);
    rst_n_v = '1;
    @(negedge clk);
    check("ready after release", 32'(ready), 32'hF);

    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].k, vecs[v].word, 1'b0, -1, $sformatf("vec%0d", v), da, cap, t1);
      check($sformatf("vec%0d bits", v), 32'(cap), 32'(vecs[v].exp_cap));
      check($sformatf("vec%0d len", v), 32'(da), 32'(vecs[v].exp_len));
    end

    // Back-to-back with tx_valid held: one idle clock between frames.
    send_frame(0, 9'h0C2, 1'b1, -1, "b2b C2", da, cap, t1);
    send_frame(0, 9'h055, 1'b1, -1, "b2b 55", da, cap, t2);
    valid_v[0] = 1'b0;
    check("b2b start spacing clocks", 32'((t2 - t1) / 20), 32'd4341);
    check("b2b second bits", 32'(cap), 32'h02AA);

    // Data and tx_valid disturbed during data bit 3: frame and idle unaffected.
    send_frame(0, 9'h0FF, 1'b0, 4 * 434 + 10, "busy change", da, cap, t1);
    check("busy change bits", 32'(cap), 32'h03FE);
    nd = 0;
    repeat (20) begin @(negedge clk); nd += int'(busy[0]) + int'(!txd[0]); end
    check("no queued frame", 32'(nd), 32'd0);

    // Reset during data bit 2 of 8'h0F.
    din[0] = 9'h00F;
    valid_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_v[0] = 1'b0;
    nd = 0;
    repeat (3 * 434 + 5) begin @(negedge clk); nd += int'(done[0]); end
    rst_n_v[0] = 1'b0;
    @(negedge clk);
    check("midreset rdy/busy/txd/done", {28'd0, ready[0], busy[0], txd[0], done[0]}, 32'b0010);
    repeat (2) begin @(negedge clk); nd += int'(done[0]); end
    rst_n_v[0] = 1'b1;
    @(negedge clk);
    check("midreset ready after release", 32'(ready[0]), 32'd1);
    repeat (6 * 434) begin @(negedge clk); nd += int'(done[0]) + int'(!txd[0]) + int'(busy[0]); end
    check("midreset no done/activity", 32'(nd), 32'd0);

    // Random words against the reference model.
    for (int k = 1; k < NK; k++) begin
      for (int r = 0; r < 10; r++) begin
        w = 9'($urandom_range(0, 511));
        send_frame(k, w, bit'($urandom_range(0, 1)), -1, $sformatf("rand k%0d #%0d", k, r),
                   da, cap, t1);
      end
      valid_v[k] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
